pad_input: RTL

PAD_INPUT -- requirements
Module: pad_input

---
 rtl/pad_input.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pad_input.sv
// Dance-pad input conditioning: per-channel synchronizer and debouncer,
// one-deep per-channel pending slots, fixed-priority arbiter and an event FIFO.
module pad_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pad_raw,
  output logic [3:0] pad,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_pad,
  output logic       evt_press,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_LAST_I = DEBOUNCE_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0] ch;
    logic       press;
  } evt_t;

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] chan_evt;
  logic [NUM_CH-1:0] pend_vld;
  logic [NUM_CH-1:0] pend_press;
  logic [NUM_CH-1:0] grant;
  logic [1:0]        grant_idx;
  logic              push;
  logic              pop;
  logic              full;
  logic              can_push;
  logic              lost;
  evt_t              mem [FIFO_DEPTH];
  evt_t              head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  // Two-flop synchronizer; idle (released) level is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= pad_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: level follows the synchronized bit after DEBOUNCE_CYCLES differing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad      <= 4'b1111;
      chan_evt <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        chan_evt[i] <= 1'b0;
        if (sync2[i] == pad[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          pad[i]      <= sync2[i];
          cnt[i]      <= '0;
          chan_evt[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pop      = evt_valid && evt_ready;
  assign full     = (count == FIFO_FULL_CNT);
  assign can_push = !full || pop;

  // Fixed-priority arbiter: lowest pending channel wins the single FIFO write slot
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    push      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend_vld[i] && !push && can_push) begin
        grant[i]  = 1'b1;
        grant_idx = 2'(i);
        push      = 1'b1;
      end
    end
  end

  // An event is lost when its channel slot is still occupied and not draining this cycle
  assign lost = |(chan_evt & pend_vld & ~grant);

  // Pending slots; pad already carries the new level when chan_evt is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld   <= '0;
      pend_press <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (chan_evt[i]) begin
          pend_vld[i]   <= 1'b1;
          pend_press[i] <= ~pad[i];
        end else if (grant[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow; a new loss outranks a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (lost) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Event FIFO storage and pointers; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{ch: grant_idx, press: pend_press[grant_idx]};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_pad   = head.ch;
  assign evt_press = head.press;

endmodule
